scl_line_ctrl: RTL and testbench

Line/frame sequencer for the horizontal scaler filter (`pixel_process`). It fetches each buffered input line from the line buffer and presents it to the filter as one contiguous enable window. Between windows it inserts the blanking the filter's edge logic needs, and holds the filter's phase and mode configuration stable for a whole frame. It sits between the line-buffer writer and the filter, and reports line and frame completion from the filter's output-valid.

---
 rtl/scl_pkg.sv | 25 ++
 rtl/scl_blank_cnt.sv | 30 +++
 rtl/scl_line_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_scl_line_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scl_pkg.sv
// Shared types and constants for the scaler line/frame sequencer.
package scl_pkg;

  // Width of the pixel, line and address counters.
  localparam int SCL_W_BITS    = 12;
  // Smallest blank gap the filter edge-detect taps can tolerate.
  localparam int SCL_MIN_BLANK = 6;
  // Narrowest line the filter can process.
  localparam int SCL_MIN_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_READ,
    ST_BLANK,
    ST_DRAIN
  } scl_state_e;

  // Effective blank length: the requested value, never below the floor.
  function automatic logic [7:0] scl_blank_len(input logic [7:0] req,
                                               input logic [7:0] floor_len);
    return (req > floor_len) ? req : floor_len;
  endfunction

endpackage

// File: rtl/scl_blank_cnt.sv
// Loadable down-counter with a terminal flag; times the inter-line blank.
module scl_blank_cnt
  import scl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_scl,
  input  logic         rst_scl,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk_scl or posedge rst_scl) begin
    if (rst_scl) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/scl_line_ctrl.sv
// Line/frame sequencer: reads each buffered line as one contiguous enable
// window for the scaler filter, inserts blanking between lines, holds the
// filter configuration for a frame and tracks completion from o_dff5.
module scl_line_ctrl
  import scl_pkg::*;
#(
  parameter int MIN_BLANK = SCL_MIN_BLANK
) (
  input  logic                  clk_scl,
  input  logic                  rst_scl,
  input  logic                  frame_start,
  input  logic [SCL_W_BITS-1:0] cfg_width,
  input  logic [SCL_W_BITS-1:0] cfg_height,
  input  logic [7:0]            cfg_hblank,
  input  logic [1:0]            cfg_flt_in,
  input  logic                  cfg_mode_in,
  input  logic                  src_line_rdy,
  output logic                  src_line_ack,
  output logic                  lb_rd_en,
  output logic [SCL_W_BITS-1:0] lb_rd_addr,
  input  logic [7:0]            lb_rd_data,
  output logic [7:0]            scl_i_data_r,
  output logic                  scl_i_data_en,
  output logic [1:0]            scl_cfg_flt,
  output logic                  scl_cfg_mode,
  input  logic                  o_dff5,
  output logic                  busy,
  output logic                  line_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam logic [7:0]            MIN_BLANK_L = 8'(MIN_BLANK);
  localparam logic [SCL_W_BITS-1:0] MIN_WIDTH_L = SCL_W_BITS'(SCL_MIN_WIDTH);

  scl_state_e            state_reg, state_next;

  logic [SCL_W_BITS-1:0] width_reg, height_reg;
  logic [7:0]            blank_reg;
  logic [1:0]            flt_reg;
  logic                  mode_reg;

  logic [SCL_W_BITS-1:0] addr_reg;
  logic [SCL_W_BITS-1:0] lines_in_reg;
  logic [SCL_W_BITS-1:0] lines_out_reg, lines_out_next;

  logic                  data_en_reg;
  logic                  dff5_d_reg;
  logic                  line_done_reg, frame_done_reg, cfg_err_reg;

  logic                  cfg_illegal;
  logic                  accept;
  logic                  cfg_err_next;
  logic                  frame_done_next;
  logic                  rd_en;
  logic                  last_rd;
  logic                  blank_load, blank_en, blank_done;
  logic [7:0]            blank_load_val;
  logic                  fall_valid;

  assign cfg_illegal = (cfg_width < MIN_WIDTH_L) || (cfg_height == '0);

  // Filter output-valid falls are only meaningful while a frame is active.
  assign fall_valid     = dff5_d_reg & ~o_dff5 & (state_reg != ST_IDLE);
  assign lines_out_next = lines_out_reg + SCL_W_BITS'(fall_valid);

  // The single WAIT_LINE sampling cycle is the last blank cycle, so BLANK
  // itself lasts blank-1 cycles; the counter ends at zero, hence blank-2.
  // This relies on MIN_BLANK being at least 2.
  assign blank_load_val = blank_reg - 8'd2;

  scl_blank_cnt #(
    .W (8)
  ) u_blank_cnt (
    .clk_scl  (clk_scl),
    .rst_scl  (rst_scl),
    .load     (blank_load),
    .load_val (blank_load_val),
    .en       (blank_en),
    .done     (blank_done)
  );

  // State register.
  always_ff @(posedge clk_scl or posedge rst_scl) begin
    if (rst_scl) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next      = state_reg;
    accept          = 1'b0;
    cfg_err_next    = 1'b0;
    frame_done_next = 1'b0;
    rd_en           = 1'b0;
    last_rd         = 1'b0;
    blank_load      = 1'b0;
    blank_en        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          if (cfg_illegal) begin
            cfg_err_next = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ST_WAIT_LINE;
          end
        end
      end
      ST_WAIT_LINE: begin
        if (src_line_rdy) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        rd_en = 1'b1;
        if (addr_reg == width_reg - 1'b1) begin
          last_rd    = 1'b1;
          blank_load = 1'b1;
          state_next = ST_BLANK;
        end
      end
      ST_BLANK: begin
        blank_en = 1'b1;
        if (blank_done) begin
          state_next = (lines_in_reg < height_reg) ? ST_WAIT_LINE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (lines_out_next >= height_reg) begin
          frame_done_next = 1'b1;
          state_next      = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Frame shadow configuration, captured only on an accepted frame_start.
  always_ff @(posedge clk_scl or posedge rst_scl) begin
    if (rst_scl) begin
      width_reg  <= '0;
      height_reg <= '0;
      blank_reg  <= '0;
      flt_reg    <= '0;
      mode_reg   <= 1'b0;
    end else if (accept) begin
      width_reg  <= cfg_width;
      height_reg <= cfg_height;
      blank_reg  <= scl_blank_len(cfg_hblank, MIN_BLANK_L);
      flt_reg    <= cfg_flt_in;
      mode_reg   <= cfg_mode_in;
    end
  end

  // Read address and input/output line counters.
  always_ff @(posedge clk_scl or posedge rst_scl) begin
    if (rst_scl) begin
      addr_reg      <= '0;
      lines_in_reg  <= '0;
      lines_out_reg <= '0;
    end else begin
      if (rd_en && !last_rd) begin
        addr_reg <= addr_reg + 1'b1;
      end else begin
        addr_reg <= '0;
      end
      if (accept) begin
        lines_in_reg  <= '0;
        lines_out_reg <= '0;
      end else begin
        if (last_rd) begin
          lines_in_reg <= lines_in_reg + 1'b1;
        end
        lines_out_reg <= lines_out_next;
      end
    end
  end

  // Enable delay matching read latency, edge detect and status pulses.
  always_ff @(posedge clk_scl or posedge rst_scl) begin
    if (rst_scl) begin
      data_en_reg    <= 1'b0;
      dff5_d_reg     <= 1'b0;
      line_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      data_en_reg    <= rd_en;
      dff5_d_reg     <= o_dff5;
      line_done_reg  <= fall_valid;
      frame_done_reg <= frame_done_next;
      cfg_err_reg    <= cfg_err_next;
    end
  end

  assign lb_rd_en      = rd_en;
  assign lb_rd_addr    = rd_en ? addr_reg : '0;
  assign src_line_ack  = last_rd;
  assign scl_i_data_en = data_en_reg;
  assign scl_i_data_r  = data_en_reg ? lb_rd_data : 8'd0;
  assign scl_cfg_flt   = flt_reg;
  assign scl_cfg_mode  = mode_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign line_done     = line_done_reg;
  assign frame_done    = frame_done_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_scl_line_ctrl.sv
// Directed self-checking bench for scl_line_ctrl with a line-buffer model
// (data = addr ^ 0x5A, one cycle latency) and a filter model whose
// output-valid is the data enable delayed by four cycles.
module tb_scl_line_ctrl;

  logic        clk_scl = 1'b0;
  logic        rst_scl = 1'b1;
  logic        frame_start = 1'b0;
  logic [11:0] cfg_width = 12'd0;
  logic [11:0] cfg_height = 12'd0;
  logic [7:0]  cfg_hblank = 8'd0;
  logic [1:0]  cfg_flt_in = 2'd0;
  logic        cfg_mode_in = 1'b0;
  logic        src_line_rdy = 1'b0;
  logic        src_line_ack;
  logic        lb_rd_en;
  logic [11:0] lb_rd_addr;
  logic [7:0]  lb_rd_data = 8'd0;
  logic [7:0]  scl_i_data_r;
  logic        scl_i_data_en;
  logic [1:0]  scl_cfg_flt;
  logic        scl_cfg_mode;
  logic        o_dff5;
  logic        busy, line_done, frame_done, cfg_err;

  logic [3:0]  dly = 4'd0;
  logic        dff5_force = 1'b0;

  scl_line_ctrl #(.MIN_BLANK(6)) dut (
    .clk_scl       (clk_scl),
    .rst_scl       (rst_scl),
    .frame_start   (frame_start),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_hblank    (cfg_hblank),
    .cfg_flt_in    (cfg_flt_in),
    .cfg_mode_in   (cfg_mode_in),
    .src_line_rdy  (src_line_rdy),
    .src_line_ack  (src_line_ack),
    .lb_rd_en      (lb_rd_en),
    .lb_rd_addr    (lb_rd_addr),
    .lb_rd_data    (lb_rd_data),
    .scl_i_data_r  (scl_i_data_r),
    .scl_i_data_en (scl_i_data_en),
    .scl_cfg_flt   (scl_cfg_flt),
    .scl_cfg_mode  (scl_cfg_mode),
    .o_dff5        (o_dff5),
    .busy          (busy),
    .line_done     (line_done),
    .frame_done    (frame_done),
    .cfg_err       (cfg_err)
  );

  always #5 clk_scl = ~clk_scl;

  // Line buffer model.
  always @(posedge clk_scl) begin
    if (lb_rd_en) lb_rd_data <= lb_rd_addr[7:0] ^ 8'h5A;
  end

  // Filter model.
  always @(posedge clk_scl) dly <= {dly[2:0], scl_i_data_en};
  assign o_dff5 = dly[3] | dff5_force;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int addr_q[$];
  int win_q[$];
  int gap_q[$];
  int run_len, low_run;
  bit seen_win, prev_en, prev_rd_en;
  int prev_addr;
  int first_rd_cyc, first_en_cyc;
  int ld_cnt, fd_cnt, fd_with_ld, ack_cnt, err_cnt, busy_cnt;
  int data_errs, reads_low, flt_bad;
  int flt_hold;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0d", tag, obs);
    end
  endtask

  task automatic clear_stats();
    addr_q.delete(); win_q.delete(); gap_q.delete();
    run_len = 0; low_run = 0; seen_win = 0;
    first_rd_cyc = -1; first_en_cyc = -1;
    ld_cnt = 0; fd_cnt = 0; fd_with_ld = 0; ack_cnt = 0; err_cnt = 0;
    busy_cnt = 0; data_errs = 0; reads_low = 0; flt_bad = 0;
  endtask

  // Advance to the next falling edge and record everything observed there.
  task automatic tick();
    @(negedge clk_scl);
    cyc++;
    if (lb_rd_en) begin
      addr_q.push_back(int'(lb_rd_addr));
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (!src_line_rdy) reads_low++;
    end
    if (scl_i_data_en) begin
      if (first_en_cyc < 0) first_en_cyc = cyc;
      if (!prev_rd_en || scl_i_data_r !== (8'(prev_addr) ^ 8'h5A)) data_errs++;
      if (!prev_en) begin
        if (seen_win) gap_q.push_back(low_run);
        run_len = 1;
      end else run_len++;
    end else begin
      if (scl_i_data_r !== 8'd0) data_errs++;
      if (prev_en) begin
        win_q.push_back(run_len);
        seen_win = 1;
        low_run = 1;
      end else low_run++;
    end
    prev_en    = scl_i_data_en;
    prev_rd_en = lb_rd_en;
    prev_addr  = int'(lb_rd_addr);
    if (line_done) ld_cnt++;
    if (frame_done) begin
      fd_cnt++;
      if (line_done) fd_with_ld++;
    end
    if (src_line_ack) ack_cnt++;
    if (cfg_err) err_cnt++;
    if (busy) busy_cnt++;
    if (int'(scl_cfg_flt) != flt_hold) flt_bad++;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag, input int budget);
    int n = 0;
    int start = fd_cnt;
    while (fd_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_frame_done_seen"}, fd_cnt - start, 1);
  endtask

  task automatic check_addrs(input string tag, input int width, input int lines);
    int errs = 0;
    check_eq({tag, "_addr_count"}, addr_q.size(), width * lines);
    for (int i = 0; i < addr_q.size(); i++) begin
      if (addr_q[i] != (i % width)) errs++;
    end
    check_eq({tag, "_addr_seq_errs"}, errs, 0);
  endtask

  task automatic set_cfg(input int w, input int h, input int hb, input int flt, input bit mode);
    cfg_width   = 12'(w);
    cfg_height  = 12'(h);
    cfg_hblank  = 8'(hb);
    cfg_flt_in  = 2'(flt);
    cfg_mode_in = mode;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_fs;
    int n;
    clear_stats();
    prev_en = 0; prev_rd_en = 0; prev_addr = 0; flt_hold = 0;

    // Reset state.
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", lb_rd_en, 0);
    check_eq("rst_rd_addr", lb_rd_addr, 0);
    check_eq("rst_data_en", scl_i_data_en, 0);
    check_eq("rst_flags", {src_line_ack, line_done, frame_done, cfg_err, scl_cfg_mode, scl_cfg_flt}, 0);
    tick();
    rst_scl = 1'b0;
    tick();

    // Basic frame: width 8, height 2, hblank 0 (raised to 6), rdy held high.
    set_cfg(8, 2, 0, 1, 1'b1);
    src_line_rdy = 1'b1;
    clear_stats();
    flt_hold = 1;
    pulse_start();
    cyc_fs = cyc;
    check_eq("t1_busy_after_start", busy, 1);
    check_eq("t1_shadow_flt", scl_cfg_flt, 1);
    check_eq("t1_shadow_mode", scl_cfg_mode, 1);
    wait_frame_done("t1", 200);
    check_eq("t1_first_rd_latency", first_rd_cyc - cyc_fs, 1);
    check_eq("t1_first_en_latency", first_en_cyc - first_rd_cyc, 1);
    check_addrs("t1", 8, 2);
    check_eq("t1_windows", win_q.size(), 2);
    check_eq("t1_win0_len", (win_q.size() > 0) ? win_q[0] : -1, 8);
    check_eq("t1_win1_len", (win_q.size() > 1) ? win_q[1] : -1, 8);
    check_eq("t1_gap", (gap_q.size() > 0) ? gap_q[0] : -1, 6);
    check_eq("t1_line_done", ld_cnt, 2);
    check_eq("t1_ack", ack_cnt, 2);
    check_eq("t1_fd_with_ld", fd_with_ld, 1);
    check_eq("t1_data", data_errs, 0);
    tick();
    check_eq("t1_idle_after", busy, 0);

    // Illegal configurations.
    clear_stats();
    set_cfg(3, 2, 0, 1, 1'b1);
    pulse_start();
    tick();
    check_eq("t2_err_width3", err_cnt, 1);
    set_cfg(8, 0, 0, 1, 1'b1);
    pulse_start();
    tick();
    tick();
    check_eq("t2_err_total", err_cnt, 2);
    check_eq("t2_busy_cycles", busy_cnt, 0);

    // Long blank, source not ready for 10 cycles beyond the blank,
    // filter phase changed mid-frame.
    clear_stats();
    set_cfg(4, 2, 20, 0, 1'b0);
    src_line_rdy = 1'b1;
    flt_hold = 0;
    pulse_start();
    check_eq("t3_shadow_flt", scl_cfg_flt, 0);
    check_eq("t3_shadow_mode", scl_cfg_mode, 0);
    cfg_flt_in = 2'd3;
    n = 0;
    while (ack_cnt == 0 && n < 50) begin
      tick();
      n++;
    end
    check_eq("t3_first_ack", ack_cnt, 1);
    src_line_rdy = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    src_line_rdy = 1'b1;
    wait_frame_done("t3", 300);
    check_addrs("t3", 4, 2);
    check_eq("t3_gap", (gap_q.size() > 0) ? gap_q[0] : -1, 30);
    check_eq("t3_reads_while_low", reads_low, 0);
    check_eq("t3_line_done", ld_cnt, 2);
    check_eq("t3_data", data_errs, 0);
    tick();
    check_eq("t3_flt_unchanged_cycles", flt_bad, 0);

    // frame_start during READ is ignored.
    clear_stats();
    set_cfg(10, 1, 0, 3, 1'b1);
    flt_hold = 3;
    pulse_start();
    check_eq("t5_shadow_flt", scl_cfg_flt, 3);
    cfg_flt_in = 2'd2;
    cfg_width  = 12'd5;
    n = 0;
    while (!(lb_rd_en && lb_rd_addr == 12'd3) && n < 20) begin
      tick();
      n++;
    end
    check_eq("t5_reached_addr3", lb_rd_addr, 3);
    pulse_start();
    wait_frame_done("t5", 100);
    check_addrs("t5", 10, 1);
    check_eq("t5_windows", win_q.size(), 1);
    check_eq("t5_cfg_err", err_cnt, 0);
    check_eq("t5_flt_held", flt_bad, 0);
    check_eq("t5_line_done", ld_cnt, 1);

    // Reset mid-line at address 5.
    clear_stats();
    set_cfg(8, 1, 0, 1, 1'b1);
    flt_hold = 1;
    pulse_start();
    n = 0;
    while (!(lb_rd_en && lb_rd_addr == 12'd5) && n < 20) begin
      tick();
      n++;
    end
    check_eq("t6_reached_addr5", lb_rd_addr, 5);
    rst_scl = 1'b1;
    tick();
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_rd_en", lb_rd_en, 0);
    check_eq("t6_rst_addr", lb_rd_addr, 0);
    check_eq("t6_rst_data_en", scl_i_data_en, 0);
    check_eq("t6_rst_flt", scl_cfg_flt, 0);
    rst_scl = 1'b0;
    flt_hold = 0;
    for (int i = 0; i < 10; i++) tick();
    dff5_force = 1'b1;
    tick(); tick();
    dff5_force = 1'b0;
    tick(); tick();
    check_eq("t6_no_ack_aborted", ack_cnt, 0);
    check_eq("t6_no_frame_done", fd_cnt, 0);
    check_eq("t6_idle_edges_ignored", ld_cnt, 0);

    clear_stats();
    set_cfg(6, 1, 0, 2, 1'b0);
    flt_hold = 2;
    pulse_start();
    wait_frame_done("t6b", 100);
    check_addrs("t6b", 6, 1);
    check_eq("t6b_ack", ack_cnt, 1);
    check_eq("t6b_line_done", ld_cnt, 1);
    check_eq("t6b_data", data_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
